// File: rtl/roceTypes.sv
// Shared RoCE types: request/ack descriptors, opcodes and the ack-queue entry.
// Used by rdma_ack_gen (optional statistics enabled by RDMA_ACK_STATS_EN).
package roceTypes;

  localparam logic [4:0] RC_SEND_ONLY         = 5'h04;
  localparam logic [4:0] RC_RDMA_WRITE_ONLY   = 5'h0A;
  localparam logic [4:0] RC_RDMA_READ_REQUEST = 5'h0C;

  // Issued request descriptor, 256 bits wide.
  typedef struct packed {
    logic [4:0]  opcode;
    logic [9:0]  qpn;
    logic [23:0] ssn;
    logic        cmplt;
    logic [63:0] vaddr;
    logic [31:0] rkey;
    logic [31:0] len;
    logic [87:0] rsvd;
  } rdma_req_t;

  // Generated ack, 36 bits wide.
  typedef struct packed {
    logic        rd;
    logic        cmplt;
    logic [5:0]  pid;
    logic [3:0]  vfid;
    logic [23:0] ssn;
  } rdma_ack_t;

  typedef struct packed {
    logic        rd;
    logic        cmplt;
    logic [9:0]  qpn;
    logic [23:0] ssn;
  } ack_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } ack_state_e;

  function automatic rdma_ack_t make_ack(input ack_entry_t e);
    rdma_ack_t a;
    a.rd    = e.rd;
    a.cmplt = 1'b1;
    a.pid   = e.qpn[5:0];
    a.vfid  = e.qpn[9:6];
    a.ssn   = e.ssn;
    return a;
  endfunction

endpackage

// File: rtl/rdma_ack_queue.sv
// In-order synchronous FIFO of outstanding requests; head is visible
// combinationally so the completion matcher can compare in the same cycle.
module rdma_ack_queue
  import roceTypes::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     push,
  input  ack_entry_t               push_data,
  input  logic                     pop,
  output ack_entry_t               head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  ack_entry_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic [AW:0]       count_next;

  // Storage carries no reset; validity is tracked by the occupancy count.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/rdma_ack_gen.sv
// Matches stack completions against in-order issued requests and emits acks.
// Define RDMA_ACK_STATS_EN to enable the outstanding/err_cnt statistics.
module rdma_ack_gen
  import roceTypes::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    s_req_valid,
  output logic                    s_req_ready,
  input  rdma_req_t               s_req_data,
  input  logic                    s_cmpl_valid,
  output logic                    s_cmpl_ready,
  input  logic [9:0]              s_cmpl_qpn,
  input  logic [23:0]             s_cmpl_msn,
  output logic                    m_ack_valid,
  input  logic                    m_ack_ready,
  output rdma_ack_t               m_ack_data,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic [15:0]             err_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  ack_state_e      state_reg, state_next;
  rdma_ack_t       ack_reg;
  ack_entry_t      head;
  ack_entry_t      push_entry;
  logic [CW-1:0]   q_count;
  logic            q_full, q_empty;
  logic            push, cmpl_fire, match, emit_start;
  logic            unused_req_bits;

  assign q_full  = (q_count == CW'(DEPTH));
  assign q_empty = (q_count == '0);

  // Readies drop combinationally while reset is asserted.
  assign s_req_ready  = aresetn && !q_full;
  assign s_cmpl_ready = aresetn && (state_reg == IDLE);

  assign push       = s_req_valid && s_req_ready;
  assign cmpl_fire  = s_cmpl_valid && s_cmpl_ready;
  assign match      = cmpl_fire && !q_empty &&
                      (s_cmpl_qpn == head.qpn) && (s_cmpl_msn == head.ssn);
  assign emit_start = match && head.cmplt;

  assign push_entry.rd    = (s_req_data.opcode == RC_RDMA_READ_REQUEST);
  assign push_entry.cmplt = s_req_data.cmplt;
  assign push_entry.qpn   = s_req_data.qpn;
  assign push_entry.ssn   = s_req_data.ssn;

  assign unused_req_bits = ^{s_req_data.vaddr, s_req_data.rkey,
                             s_req_data.len, s_req_data.rsvd};

  rdma_ack_queue #(.DEPTH(DEPTH)) u_queue (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (push),
    .push_data (push_entry),
    .pop       (match),
    .head      (head),
    .count     (q_count)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (emit_start) state_next = EMIT;
      EMIT:    if (m_ack_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= IDLE;
      ack_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (emit_start) ack_reg <= make_ack(head);
    end
  end

  assign m_ack_valid = (state_reg == EMIT);
  assign m_ack_data  = ack_reg;

`ifdef RDMA_ACK_STATS_EN
  logic [15:0] err_cnt_reg;

  // Unmatched or empty-queue completions are consumed and counted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_cnt_reg <= '0;
    end else if (cmpl_fire && !match && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign err_cnt     = err_cnt_reg;
  assign outstanding = q_count;
`else
  assign err_cnt     = '0;
  assign outstanding = '0;
`endif

endmodule
